mode_counter: RTL and testbench

Parametrised up/down step counter with bounded range, three counting modes, synchronous load and terminal-count signalling. Successor to the loadable 8-bit counter in the Lab 1 datapath; drives the 7-segment/display path and serves as a programmable timer for later labs. One clock domain, fully synchronous.

---
 rtl/mode_counter_if.sv | 27 ++
 rtl/mode_counter.sv | 148 ++++++++++++++
 tb/tb_mode_counter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mode_counter_if.sv
// Bus bundle for mode_counter: control/config inputs from the master,
// registered count and status back from the counter.
interface mode_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;
  logic             busy;

  modport master (
    output en, load, load_val, up, mode, limit, step,
    input  count, tc, done, busy
  );

  modport slave (
    input  en, load, load_val, up, mode, limit, step,
    output count, tc, done, busy
  );
endinterface

// File: rtl/mode_counter.sv
// Bounded up/down step counter with free-run, saturate and one-shot modes.
// Define MODE_COUNTER_PRESCALE_EN to step only on every PRESCALE-th enabled cycle.
module mode_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst,
  mode_counter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             oneShotEnd;
  logic [1:0]       modeEff;
  logic [WIDTH:0]   sumWide;
  logic             tick;

  // Candidate result of a step; the extra sum bit keeps overflow visible.
  always_comb begin
    modeEff    = (bus.mode == 2'b11) ? 2'b00 : bus.mode;
    sumWide    = {1'b0, count_q} + {1'b0, bus.step};
    count_d    = count_q;
    tc_d       = 1'b0;
    oneShotEnd = 1'b0;
    if (bus.step != '0) begin
      if (bus.up) begin
        if (sumWide > {1'b0, bus.limit}) begin
          case (modeEff)
            2'b01: begin
              count_d = bus.limit;
              tc_d    = (count_q != bus.limit);
            end
            2'b10: begin
              count_d    = bus.limit;
              tc_d       = 1'b1;
              oneShotEnd = 1'b1;
            end
            default: begin
              count_d = '0;
              tc_d    = 1'b1;
            end
          endcase
        end else begin
          count_d = sumWide[WIDTH-1:0];
        end
      end else begin
        if (count_q < bus.step) begin
          case (modeEff)
            2'b01: begin
              count_d = '0;
              tc_d    = (count_q != '0);
            end
            2'b10: begin
              count_d    = '0;
              tc_d       = 1'b1;
              oneShotEnd = 1'b1;
            end
            default: begin
              count_d = bus.limit;
              tc_d    = 1'b1;
            end
          endcase
        end else begin
          count_d = count_q - bus.step;
        end
      end
    end
  end

`ifdef MODE_COUNTER_PRESCALE_EN
  localparam int DivW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(PRESCALE - 1);

  logic [DivW-1:0] div_q;
  logic            enterDone;

  assign tick      = (div_q == DivLast);
  assign enterDone = bus.en && tick && (state_q != DONE) && oneShotEnd;

  // Divider advances only on enabled cycles outside DONE.
  always_ff @(posedge clk) begin
    if (rst || bus.load || enterDone) begin
      div_q <= '0;
    end else if (bus.en && (state_q != DONE)) begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end
`else
  assign tick = (PRESCALE >= 1) ? 1'b1 : 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.load) begin
      state_q <= IDLE;
      count_q <= (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (bus.en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            if (tick) begin
              count_q <= count_d;
              tc_q    <= tc_d;
              if (oneShotEnd) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mode_counter.sv
// Testbench for mode_counter: directed literal sequences plus randomized
// traffic checked every cycle against an arithmetic reference model.
module tb_mode_counter;
  localparam int W  = 9;
  localparam int PS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mode_counter_if #(.WIDTH(W)) bus ();

  mode_counter #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit checkOn    = 1'b0;

  int mCount = 0;
  bit mTc    = 1'b0;
  bit mDone  = 1'b0;
  bit mRun   = 1'b0;
  int mDiv   = 0;

  // Reference model: plain integer arithmetic on the counting rules.
  always @(posedge clk) begin : refModel
    int  lim, stp, md, target;
    bit  doStep, crossed;
    if (rst) begin
      mCount = 0; mTc = 0; mDone = 0; mRun = 0; mDiv = 0;
    end else if (bus.load) begin
      mCount = (int'(bus.load_val) > int'(bus.limit)) ? int'(bus.limit) : int'(bus.load_val);
      mTc = 0; mDone = 0; mRun = 0; mDiv = 0;
    end else begin
      mTc = 0;
      if (!mDone && bus.en) begin
        mRun   = 1;
        doStep = 1;
`ifdef MODE_COUNTER_PRESCALE_EN
        mDiv   = mDiv + 1;
        doStep = (mDiv == PS);
        if (doStep) mDiv = 0;
`endif
        lim     = int'(bus.limit);
        stp     = int'(bus.step);
        md      = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
        crossed = 0;
        if (doStep && stp != 0) begin
          if (bus.up) begin
            if (mCount + stp > lim) crossed = 1;
            else mCount = mCount + stp;
          end else begin
            if (mCount - stp < 0) crossed = 1;
            else mCount = mCount - stp;
          end
          if (crossed) begin
            target = bus.up ? lim : 0;
            if (md == 0) begin
              mCount = bus.up ? 0 : lim;
              mTc    = 1;
            end else if (md == 1) begin
              mTc    = (mCount != target);
              mCount = target;
            end else begin
              mCount = target;
              mTc    = 1;
              mDone  = 1;
              mRun   = 0;
              mDiv   = 0;
            end
          end
        end
      end
    end
  end

  task automatic checkValue(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input int c, input int t, input int d, input int b);
    checkValue({tag, ".count"}, int'(bus.count), c);
    checkValue({tag, ".tc"},    int'(bus.tc),    t);
    checkValue({tag, ".done"},  int'(bus.done),  d);
    checkValue({tag, ".busy"},  int'(bus.busy),  b);
  endtask

  // Every cycle, compare the DUT against the model away from the clock edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkValue("model.count", int'(bus.count), mCount);
      checkValue("model.tc",    int'(bus.tc),    int'(mTc));
      checkValue("model.done",  int'(bus.done),  int'(mDone));
      checkValue("model.busy",  int'(bus.busy),  int'(mRun));
    end
  end

  task automatic applyStimulus(input bit rstV, input bit loadV, input int loadValV, input bit enV,
                               input bit upV, input int modeV, input int limitV, input int stepV);
    rst          = rstV;
    bus.load     = loadV;
    bus.load_val = loadValV[W-1:0];
    bus.en       = enV;
    bus.up       = upV;
    bus.mode     = modeV[1:0];
    bus.limit    = limitV[W-1:0];
    bus.step     = stepV[W-1:0];
  endtask

  task automatic waitCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int satCnt [5] = '{3, 1, 0, 0, 0};
    int satTc  [5] = '{0, 0, 1, 0, 0};
    int rLimit = 20;
    int rStep  = 1;
    int rMode  = 0;
    bit rUp    = 1'b1;
    int sel;

    applyStimulus(1, 0, 0, 0, 1, 0, 9, 1);
    repeat (2) waitCycle();
    checkOn = 1'b1;
    checkOutput("reset", 0, 0, 0, 0);

`ifndef MODE_COUNTER_PRESCALE_EN
    applyStimulus(0, 0, 0, 1, 1, 0, 9, 1);
    for (int i = 1; i <= 11; i++) begin
      waitCycle();
      checkOutput("freerun", i % 10, (i == 10) ? 1 : 0, 0, 1);
    end

    applyStimulus(0, 1, 5, 0, 0, 1, 200, 2);
    waitCycle();
    checkOutput("sat.load", 5, 0, 0, 0);
    applyStimulus(0, 0, 5, 1, 0, 1, 200, 2);
    for (int i = 0; i < 5; i++) begin
      waitCycle();
      checkOutput("sat.down", satCnt[i], satTc[i], 0, 1);
    end

    applyStimulus(0, 1, 250, 0, 1, 2, 255, 3);
    waitCycle();
    checkOutput("oneshot.load", 250, 0, 0, 0);
    applyStimulus(0, 0, 250, 1, 1, 2, 255, 3);
    waitCycle();
    checkOutput("oneshot.step", 253, 0, 0, 1);
    waitCycle();
    checkOutput("oneshot.end", 255, 1, 1, 0);
    repeat (3) begin
      waitCycle();
      checkOutput("oneshot.hold", 255, 0, 1, 0);
    end
    applyStimulus(0, 1, 0, 1, 1, 2, 255, 3);
    waitCycle();
    checkOutput("oneshot.reload", 0, 0, 0, 0);

    applyStimulus(0, 1, 300, 1, 1, 0, 100, 1);
    waitCycle();
    checkOutput("loaden.clamp", 100, 0, 0, 0);
    applyStimulus(0, 0, 300, 1, 1, 0, 100, 1);
    waitCycle();
    checkOutput("loaden.wrap", 0, 1, 0, 1);

    applyStimulus(0, 1, 0, 0, 1, 0, 20, 1);
    waitCycle();
    applyStimulus(0, 0, 0, 1, 1, 0, 20, 1);
    repeat (7) waitCycle();
    checkOutput("midrun", 7, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 1, 0, 20, 1);
    waitCycle();
    checkOutput("midrun.rst", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 20, 0);
    repeat (3) begin
      waitCycle();
      checkOutput("step0", 0, 0, 0, 1);
    end
`else
    applyStimulus(0, 1, 0, 0, 1, 0, 50, 1);
    waitCycle();
    checkOutput("pre.load", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 50, 1);
    for (int i = 1; i <= 6; i++) begin
      waitCycle();
      checkOutput("pre.run", i / PS, 0, 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 50, 1);
    repeat (2) begin
      waitCycle();
      checkOutput("pre.pause", 1, 0, 0, 1);
    end
    applyStimulus(0, 0, 0, 1, 1, 0, 50, 1);
    waitCycle();
    checkOutput("pre.resume", 1, 0, 0, 1);
    waitCycle();
    checkOutput("pre.tick", 2, 0, 0, 1);
`endif

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        sel = $urandom_range(0, 3);
        rLimit = (sel == 0) ? 511 : (sel == 1) ? 0 : (sel == 2) ? $urandom_range(0, 15) : $urandom_range(0, 511);
      end
      if ($urandom_range(0, 15) == 0) begin
        sel = $urandom_range(0, 3);
        rStep = (sel == 0) ? 0 : (sel == 3) ? $urandom_range(0, 511) : $urandom_range(1, 4);
      end
      if ($urandom_range(0, 31) == 0) rMode = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) rUp = ~rUp;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 511),
                    $urandom_range(0, 3) != 0, rUp, rMode, rLimit, rStep);
      waitCycle();
    end

    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
